// File: rtl/lr_stream_arbiter_pkg.sv
// Shared definitions for the 2:1 packet-granular stream arbiter.
// Holds the bus width, the word-type codes carried in the top two bits
// of each word, the arbiter state encoding and a helper that pulls the
// code out of a word.
package lr_stream_arbiter_pkg;

    localparam int unsigned BUS_W = 134;

    localparam logic [1:0] CODE_HDR  = 2'b01;
    localparam logic [1:0] CODE_MID  = 2'b11;
    localparam logic [1:0] CODE_TAIL = 2'b10;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StXfer  = 2'd2
    } arb_state_e;

    function automatic logic [1:0] word_code(input logic [BUS_W-1:0] w);
        return w[BUS_W-1 -: 2];
    endfunction

endpackage

// File: rtl/lr_grant_pick.sv
// Winner selection for the stream arbiter.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_tr_req, i_rp_req  pending requests from transit / report
//   i_commit            a granted source delivered its header this cycle
//   i_commit_rp         which source committed (1 = report)
//   o_pick_rp           combinational winner (1 = report), valid when any req
// Fairness history only advances on a committed header, so a grant that
// times out never counts as a win.
module lr_grant_pick
    import lr_stream_arbiter_pkg::*;
#(
    parameter int unsigned PRIO_REPORT = 1,
    parameter int unsigned MAX_CONSEC  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tr_req,
    input  logic i_rp_req,
    input  logic i_commit,
    input  logic i_commit_rp,
    output logic o_pick_rp
);

    localparam int unsigned CW = $clog2(MAX_CONSEC + 1);

    logic          r_last_rp;
    logic [CW-1:0] r_consec;
    logic          w_rp_capped;

    // Report has used up its run of back-to-back wins.
    assign w_rp_capped = r_last_rp && (r_consec == CW'(MAX_CONSEC));

    always_comb begin
        o_pick_rp = 1'b0;
        if (i_rp_req && !i_tr_req) begin
            o_pick_rp = 1'b1;
        end else if (i_rp_req && i_tr_req) begin
            if (PRIO_REPORT != 0) begin
                o_pick_rp = !w_rp_capped;
            end else begin
                o_pick_rp = !r_last_rp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_rp <= 1'b0;
            r_consec  <= '0;
        end else if (i_commit) begin
            r_last_rp <= i_commit_rp;
            if (i_commit_rp == r_last_rp) begin
                // Saturate so the cap test stays exact on long runs.
                if (r_consec != CW'(MAX_CONSEC)) begin
                    r_consec <= r_consec + 1'b1;
                end
            end else begin
                r_consec <= CW'(1);
            end
        end
    end

endmodule

// File: rtl/lr_stream_arbiter.sv
// Packet-granular 2:1 arbiter merging the transit and beacon-report streams.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   in_tr_* / in_rp_*                 request, word strobe/data, valid flag/strobe
//   out_tr_ready / out_rp_ready       per-source grant
//   in_down_ready                     downstream accepts a new packet (IDLE only)
//   out_data_wr/out_data/out_data_valid/out_data_valid_wr  merged stream, 1-cycle latency
//   out_tr_pkt_cnt/out_rp_pkt_cnt     forwarded packets per source
//   out_drop_cnt                      dropped words
//   out_timeout_cnt                   revoked grants
module lr_stream_arbiter
    import lr_stream_arbiter_pkg::*;
#(
    parameter int unsigned PRIO_REPORT   = 1,
    parameter int unsigned MAX_CONSEC    = 4,
    parameter int unsigned GRANT_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_tr_req,
    input  logic             in_rp_req,
    input  logic             in_tr_data_wr,
    input  logic             in_rp_data_wr,
    input  logic [BUS_W-1:0] in_tr_data,
    input  logic [BUS_W-1:0] in_rp_data,
    input  logic             in_tr_data_valid,
    input  logic             in_tr_data_valid_wr,
    input  logic             in_rp_data_valid,
    input  logic             in_rp_data_valid_wr,
    output logic             out_tr_ready,
    output logic             out_rp_ready,
    input  logic             in_down_ready,
    output logic             out_data_wr,
    output logic [BUS_W-1:0] out_data,
    output logic             out_data_valid,
    output logic             out_data_valid_wr,
    output logic [31:0]      out_tr_pkt_cnt,
    output logic [31:0]      out_rp_pkt_cnt,
    output logic [31:0]      out_drop_cnt,
    output logic [15:0]      out_timeout_cnt
);

    localparam int unsigned TW = $clog2(GRANT_TIMEOUT + 1);

    arb_state_e       r_state, w_state_d;
    logic             r_tr_ready, w_tr_ready_d;
    logic             r_rp_ready, w_rp_ready_d;
    logic             r_gnt_rp, w_gnt_rp_d;
    logic [TW-1:0]    r_timer, w_timer_d;

    logic             r_out_wr, r_out_valid, r_out_valid_wr;
    logic [BUS_W-1:0] r_out_data;
    logic [31:0]      r_tr_pkt_cnt, r_rp_pkt_cnt, r_drop_cnt;
    logic [15:0]      r_timeout_cnt;

    logic             w_pick_rp;
    logic             w_g_wr, w_g_valid, w_g_valid_wr;
    logic [BUS_W-1:0] w_g_data;
    logic [1:0]       w_g_code;
    logic [1:0]       w_drop_ung;
    logic             w_fwd, w_drop_g, w_commit, w_done, w_timeout;

    lr_grant_pick #(
        .PRIO_REPORT (PRIO_REPORT),
        .MAX_CONSEC  (MAX_CONSEC)
    ) u_pick (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_tr_req    (in_tr_req),
        .i_rp_req    (in_rp_req),
        .i_commit    (w_commit),
        .i_commit_rp (r_gnt_rp),
        .o_pick_rp   (w_pick_rp)
    );

    // Word lane of whichever source currently holds (or last held) the grant.
    assign w_g_wr       = r_gnt_rp ? in_rp_data_wr       : in_tr_data_wr;
    assign w_g_data     = r_gnt_rp ? in_rp_data          : in_tr_data;
    assign w_g_valid    = r_gnt_rp ? in_rp_data_valid    : in_tr_data_valid;
    assign w_g_valid_wr = r_gnt_rp ? in_rp_data_valid_wr : in_tr_data_valid_wr;
    assign w_g_code     = word_code(w_g_data);

    // In IDLE nobody is granted, so every strobed word is lost.
    always_comb begin
        if (r_state == StIdle) begin
            w_drop_ung = {1'b0, in_tr_data_wr} + {1'b0, in_rp_data_wr};
        end else begin
            w_drop_ung = {1'b0, r_gnt_rp ? in_tr_data_wr : in_rp_data_wr};
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_tr_ready_d = r_tr_ready;
        w_rp_ready_d = r_rp_ready;
        w_gnt_rp_d   = r_gnt_rp;
        w_timer_d    = r_timer;
        w_fwd        = 1'b0;
        w_drop_g     = 1'b0;
        w_commit     = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_tr_ready_d = 1'b0;
                w_rp_ready_d = 1'b0;
                if (in_down_ready && (in_tr_req || in_rp_req)) begin
                    w_gnt_rp_d   = w_pick_rp;
                    w_rp_ready_d = w_pick_rp;
                    w_tr_ready_d = !w_pick_rp;
                    w_timer_d    = '0;
                    w_state_d    = StGrant;
                end
            end
            StGrant: begin
                if (w_g_wr && (w_g_code == CODE_HDR)) begin
                    w_fwd     = 1'b1;
                    w_commit  = 1'b1;
                    w_state_d = StXfer;
                end else begin
                    if (w_g_wr) begin
                        w_drop_g = 1'b1;
                    end
                    if (r_timer == TW'(GRANT_TIMEOUT - 1)) begin
                        w_timeout    = 1'b1;
                        w_tr_ready_d = 1'b0;
                        w_rp_ready_d = 1'b0;
                        w_state_d    = StIdle;
                    end else begin
                        w_timer_d = r_timer + 1'b1;
                    end
                end
            end
            StXfer: begin
                if (w_g_wr) begin
                    w_fwd = 1'b1;
                    // A second header mid-packet is forwarded but flagged.
                    if (w_g_code == CODE_HDR) begin
                        w_drop_g = 1'b1;
                    end
                    if (w_g_code == CODE_TAIL) begin
                        w_done       = 1'b1;
                        w_tr_ready_d = 1'b0;
                        w_rp_ready_d = 1'b0;
                        w_state_d    = StIdle;
                    end
                end
            end
            default: begin
                w_tr_ready_d = 1'b0;
                w_rp_ready_d = 1'b0;
                w_state_d    = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StIdle;
            r_tr_ready     <= 1'b0;
            r_rp_ready     <= 1'b0;
            r_gnt_rp       <= 1'b0;
            r_timer        <= '0;
            r_out_wr       <= 1'b0;
            r_out_data     <= '0;
            r_out_valid    <= 1'b0;
            r_out_valid_wr <= 1'b0;
            r_tr_pkt_cnt   <= '0;
            r_rp_pkt_cnt   <= '0;
            r_drop_cnt     <= '0;
            r_timeout_cnt  <= '0;
        end else begin
            r_state        <= w_state_d;
            r_tr_ready     <= w_tr_ready_d;
            r_rp_ready     <= w_rp_ready_d;
            r_gnt_rp       <= w_gnt_rp_d;
            r_timer        <= w_timer_d;
            r_out_wr       <= w_fwd;
            r_out_valid    <= w_fwd & w_g_valid;
            r_out_valid_wr <= w_fwd & w_g_valid_wr;
            if (w_fwd) begin
                r_out_data <= w_g_data;
            end
            if (w_done && r_gnt_rp) begin
                r_rp_pkt_cnt <= r_rp_pkt_cnt + 32'd1;
            end
            if (w_done && !r_gnt_rp) begin
                r_tr_pkt_cnt <= r_tr_pkt_cnt + 32'd1;
            end
            r_drop_cnt <= r_drop_cnt + 32'(w_drop_ung) + 32'(w_drop_g);
            if (w_timeout) begin
                r_timeout_cnt <= r_timeout_cnt + 16'd1;
            end
        end
    end

    assign out_tr_ready      = r_tr_ready;
    assign out_rp_ready      = r_rp_ready;
    assign out_data_wr       = r_out_wr;
    assign out_data          = r_out_data;
    assign out_data_valid    = r_out_valid;
    assign out_data_valid_wr = r_out_valid_wr;
    assign out_tr_pkt_cnt    = r_tr_pkt_cnt;
    assign out_rp_pkt_cnt    = r_rp_pkt_cnt;
    assign out_drop_cnt      = r_drop_cnt;
    assign out_timeout_cnt   = r_timeout_cnt;

endmodule

// File: tb/tb_lr_stream_arbiter.sv
// Bench for lr_stream_arbiter. Instance 0 has report priority, instance 1
// is round-robin. Each source is a small packet model that sends its packet
// back-to-back once granted; every word it sends while granted is pushed to
// a scoreboard with its send cycle and must reappear exactly one cycle later.
// Grant order is logged as inst*2+src (src 0 = transit, 1 = report).
module tb_lr_stream_arbiter;
    import lr_stream_arbiter_pkg::*;

    localparam int W = BUS_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         req[2][2], wr[2][2], v[2][2], vw[2][2], rdy[2][2];
    logic [W-1:0] d[2][2];
    logic         down_rdy[2];
    logic         o_wr[2], o_v[2], o_vw[2];
    logic [W-1:0] o_d[2];
    logic [31:0]  tr_cnt[2], rp_cnt[2], drop_cnt[2];
    logic [15:0]  to_cnt[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lr_stream_arbiter #(
            .PRIO_REPORT   ((g == 0) ? 1 : 0),
            .MAX_CONSEC    (4),
            .GRANT_TIMEOUT (16)
        ) u_dut (
            .clk                 (clk),
            .rst_n               (rst_n),
            .in_tr_req           (req[g][0]),
            .in_rp_req           (req[g][1]),
            .in_tr_data_wr       (wr[g][0]),
            .in_rp_data_wr       (wr[g][1]),
            .in_tr_data          (d[g][0]),
            .in_rp_data          (d[g][1]),
            .in_tr_data_valid    (v[g][0]),
            .in_tr_data_valid_wr (vw[g][0]),
            .in_rp_data_valid    (v[g][1]),
            .in_rp_data_valid_wr (vw[g][1]),
            .out_tr_ready        (rdy[g][0]),
            .out_rp_ready        (rdy[g][1]),
            .in_down_ready       (down_rdy[g]),
            .out_data_wr         (o_wr[g]),
            .out_data            (o_d[g]),
            .out_data_valid      (o_v[g]),
            .out_data_valid_wr   (o_vw[g]),
            .out_tr_pkt_cnt      (tr_cnt[g]),
            .out_rp_pkt_cnt      (rp_cnt[g]),
            .out_drop_cnt        (drop_cnt[g]),
            .out_timeout_cnt     (to_cnt[g])
        );
    end

    typedef struct {
        int           inst;
        logic [W-1:0] d;
        logic         v;
        logic         vw;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   glog[$];
    int   pend[2][2], len[2][2], pos[2][2], pkt_no[2][2], hi_cnt[2][2];
    bit   mute[2][2], inj[2][2], was_rdy[2][2];
    int   cyc;
    int   total, bad;

    task automatic check_val(input string tag, input logic [135:0] act,
                             input logic [135:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic check_log(input string tag, input int q[$]);
        check_val({tag, "_len"}, 136'(glog.size()), 136'(q.size()));
        for (int k = 0; k < q.size(); k++) begin
            if (k < glog.size()) begin
                check_val(tag, 136'(glog[k]), 136'(q[k]));
            end
        end
    endtask

    // One clock: monitor outputs, then run the source models for the next word.
    task automatic tick();
        exp_t       e;
        logic [1:0] code;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (o_wr[i]) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_out", 136'(o_wr[i]), 136'(0));
                end else begin
                    e = sb.pop_front();
                    check_val("out_inst", 136'(i), 136'(e.inst));
                    check_val("out_word", {o_d[i], o_v[i], o_vw[i]}, {e.d, e.v, e.vw});
                    check_val("out_latency", 136'(cyc), 136'(e.cyc + 1));
                end
            end
            for (int s = 0; s < 2; s++) begin
                if (rdy[i][s] && !was_rdy[i][s]) glog.push_back(i * 2 + s);
                if (rdy[i][s]) hi_cnt[i][s]++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 2; s++) begin
                wr[i][s] = 1'b0;
                v[i][s]  = 1'b0;
                vw[i][s] = 1'b0;
                d[i][s]  = '0;
                // A muted source gives up its packet once the grant is revoked.
                if (mute[i][s] && was_rdy[i][s] && !rdy[i][s]) begin
                    pend[i][s] = 0;
                    mute[i][s] = 1'b0;
                end
                if (rdy[i][s] && pend[i][s] > 0 && !mute[i][s]) begin
                    code = (pos[i][s] == 0) ? CODE_HDR :
                           (pos[i][s] == len[i][s] - 1) ? CODE_TAIL : CODE_MID;
                    d[i][s]  = {code, 92'd0, 8'(i), 8'(s), 16'(pkt_no[i][s]), 8'(pos[i][s])};
                    wr[i][s] = 1'b1;
                    v[i][s]  = (code == CODE_TAIL);
                    vw[i][s] = (code == CODE_TAIL);
                    e.inst = i;
                    e.d    = d[i][s];
                    e.v    = v[i][s];
                    e.vw   = vw[i][s];
                    e.cyc  = cyc;
                    sb.push_back(e);
                    pos[i][s]++;
                    if (code == CODE_TAIL) begin
                        pos[i][s] = 0;
                        pend[i][s]--;
                        pkt_no[i][s]++;
                    end
                end
                was_rdy[i][s] = rdy[i][s];
                req[i][s] = (pend[i][s] > 0);
            end
        end
        // Stray word from the idle source while the other is mid-packet.
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (inj[i][s] && rdy[i][1-s] && pos[i][1-s] > 1 && !wr[i][s]) begin
                    wr[i][s]  = 1'b1;
                    d[i][s]   = {CODE_MID, 132'hbad};
                    inj[i][s] = 1'b0;
                end
            end
        end
    endtask

    task automatic clear_state();
        for (int i = 0; i < 2; i++) begin
            down_rdy[i] = 1'b1;
            for (int s = 0; s < 2; s++) begin
                pend[i][s] = 0;   len[i][s] = 3;     pos[i][s] = 0;
                pkt_no[i][s] = 0; hi_cnt[i][s] = 0;  mute[i][s] = 1'b0;
                inj[i][s] = 1'b0; was_rdy[i][s] = 1'b0;
                req[i][s] = 1'b0; wr[i][s] = 1'b0;   v[i][s] = 1'b0;
                vw[i][s] = 1'b0;  d[i][s] = '0;
            end
        end
        sb.delete();
        glog.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_state();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        bit idle;
        for (int c = 0; c < 3000; c++) begin
            tick();
            idle = (sb.size() == 0);
            for (int i = 0; i < 2; i++) begin
                for (int s = 0; s < 2; s++) begin
                    if (pend[i][s] != 0 || rdy[i][s] || wr[i][s]) idle = 1'b0;
                end
            end
            if (idle) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("drain", 136'(ok), 136'(1));
    endtask

    task automatic check_cnts(input string tag, input int i, input int tr, input int rp,
                              input int dr, input int to);
        check_val({tag, "_tr_cnt"}, 136'(tr_cnt[i]), 136'(tr));
        check_val({tag, "_rp_cnt"}, 136'(rp_cnt[i]), 136'(rp));
        check_val({tag, "_drop"}, 136'(drop_cnt[i]), 136'(dr));
        check_val({tag, "_timeout"}, 136'(to_cnt[i]), 136'(to));
    endtask

    initial begin
        int exp_q[$];
        int held;
        total = 0;
        bad   = 0;
        cyc   = 0;

        // Reset state
        rst_n = 1'b0;
        clear_state();
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            check_val("rst_outs", {rdy[i][0], rdy[i][1], o_wr[i], o_v[i], o_vw[i], o_d[i]},
                      136'(0));
            check_cnts("rst", i, 0, 0, 0, 0);
        end
        rst_n = 1'b1;
        tick();

        // Single 13-word report packet
        len[0][1]  = 13;
        pend[0][1] = 1;
        tick();
        check_val("t1_rdy_early", 136'(rdy[0][1]), 136'(0));
        tick();
        check_val("t1_rdy", 136'(rdy[0][1]), 136'(1));
        wait_done();
        check_cnts("t1", 0, 0, 1, 0, 0);
        exp_q = '{1};
        check_log("t1_order", exp_q);

        // Report priority with starvation guard
        do_reset();
        pend[0][0] = 5;
        pend[0][1] = 5;
        wait_done();
        exp_q = '{1, 1, 1, 1, 0, 1, 0, 0, 0, 0};
        check_log("t2_order", exp_q);
        check_cnts("t2", 0, 5, 5, 0, 0);

        // Round-robin: one report first, then both contend
        do_reset();
        pend[1][1] = 1;
        wait_done();
        pend[1][0] = 2;
        pend[1][1] = 2;
        wait_done();
        exp_q = '{3, 2, 3, 2, 3};
        check_log("t3_order", exp_q);
        check_cnts("t3", 1, 2, 3, 0, 0);

        // Grant timeout: report never sends its header
        do_reset();
        mute[0][1] = 1'b1;
        pend[0][1] = 1;
        tick();
        pend[0][0] = 1;
        wait_done();
        check_val("t4_grant_cycles", 136'(hi_cnt[0][1]), 136'(16));
        exp_q = '{1, 0};
        check_log("t4_order", exp_q);
        check_cnts("t4", 0, 1, 0, 0, 1);

        // Stray transit word during a report packet
        do_reset();
        len[0][1]  = 8;
        pend[0][1] = 1;
        inj[0][0]  = 1'b1;
        wait_done();
        check_cnts("t5", 0, 0, 1, 1, 0);

        // Downstream not ready holds off the grant
        do_reset();
        down_rdy[0] = 1'b0;
        pend[0][1]  = 1;
        held = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rdy[0][0] || rdy[0][1]) held++;
        end
        check_val("t6_no_grant", 136'(held), 136'(0));
        down_rdy[0] = 1'b1;
        tick();
        check_val("t6_grant", 136'(rdy[0][1]), 136'(1));
        wait_done();
        check_cnts("t6", 0, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got stuck want finish");
        $fatal(1);
    end

endmodule
